// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response handshake and the DataMemory bus.
// The slave modport is the load/store unit's view. The master modport is the
// environment's view: the pipeline MEM stage plus the memory returning read data.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, MemReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  MemAddr, MemRead, MemWrite, MemWriteData
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, MemReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output MemAddr, MemRead, MemWrite, MemWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/halfword/word accesses to a
// word-addressed memory. Sub-word stores are done as read-modify-write.
// Strobes are decoded straight from the state so each lasts exactly one cycle
// and both are low in IDLE and RESP.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        range_err;
  logic        acc_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] wdata_rep;
  logic [3:0]  lane_hit;
  logic [31:0] merged;

  // Request checks on the raw inputs, evaluated in the accept cycle.
  assign range_err = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
  assign acc_err   = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                   | range_err;

  // Lane selection out of the word being read (little-endian lanes).
  always_comb begin
    rd_byte = bus.MemReadData[7:0];
    case (off_q)
      2'd0:    rd_byte = bus.MemReadData[7:0];
      2'd1:    rd_byte = bus.MemReadData[15:8];
      2'd2:    rd_byte = bus.MemReadData[23:16];
      default: rd_byte = bus.MemReadData[31:24];
    endcase
    rd_half = off_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
  end

  // Right-justify the selected lane and extend it.
  always_comb begin
    load_val = bus.MemReadData;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = bus.MemReadData;
    endcase
  end

  // Store data replicated onto every lane; the lane mask picks which one lands.
  assign wdata_rep = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = (size_q == 2'b00) ? (off_q == 2'(gi))
                                              : (off_q[1] == 1'(gi / 2));
      assign merged[8*gi +: 8] = lane_hit[gi] ? wdata_rep[8*gi +: 8]
                                              : bus.MemReadData[8*gi +: 8];
    end
  endgenerate

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          uns_d      = bus.req_unsigned;
          off_d      = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          mem_addr_d = {bus.req_addr[31:2], 2'b00};
          rdata_d    = 32'd0;
          err_d      = acc_err;
          if (acc_err) begin
            state_d = RESP;
          end else if (!bus.req_write) begin
            state_d = RD;
          end else if (bus.req_size == 2'b10) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (write_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      default: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;
  assign bus.MemRead      = (state_q == RD);
  assign bus.MemWrite     = (state_q == WR);
  assign bus.MemAddr      = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;

endmodule
